vpe_bias_bank: RTL and testbench

VPE_BIAS_BANK -- requirements
Module: vpe_bias_bank

---
 rtl/vpe_pkg.sv | 7 +
 rtl/vpe_bias_mem.sv | 23 ++
 rtl/vpe_bias_bank.sv | 91 +++++++++
 tb/tb_vpe_bias_bank.sv | 129 ++++++++++++
 4 files changed

// File: rtl/vpe_pkg.sv
// vpe_pkg: FSM state and default geometry shared by the bias bank and its storage.
package vpe_pkg;
    typedef enum logic {INIT, READY} state_t;
    localparam int LANES_DEF = 4;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF = 256;
endpackage

// File: rtl/vpe_bias_mem.sv
// vpe_bias_mem: simple dual-port RAM, one write port, one registered read port with write-forwarding.
module vpe_bias_mem #(
    parameter int W = 64,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    localparam logic [AW:0] LIM = (AW+1)'(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic wr_ok, rd_ok;
    assign wr_ok = {1'b0, waddr} < LIM;
    assign rd_ok = {1'b0, raddr} < LIM;
    always_ff @(posedge clk) begin
        if (we && wr_ok) mem[waddr] <= wdata;
        rdata <= !rd_ok ? '0 : (we && wr_ok && waddr == raddr) ? wdata : mem[raddr];
    end
endmodule

// File: rtl/vpe_bias_bank.sv
// vpe_bias_bank: zero-cleared bias RAM with 2-cycle pipelined reads.
// Optional per-lane even parity: define VPE_BIAS_BANK_PARITY_EN.
module vpe_bias_bank
    import vpe_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int DW = LANES * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DW-1:0]     wdata,
    output logic              wr_ready,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rd_ready,
    output logic [DW-1:0]     o_data,
    output logic              o_data_valid,
    output logic              init_done
`ifdef VPE_BIAS_BANK_PARITY_EN
    ,output logic [LANES-1:0] o_parity_err
`endif
);
`ifdef VPE_BIAS_BANK_PARITY_EN
    localparam int MW = DW + LANES;
    logic [LANES-1:0] par, err;
`else
    localparam int MW = DW;
`endif
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH);
    state_t state;
    logic [ADDR_W:0] cnt;
    logic rd_pend, we;
    logic [ADDR_W-1:0] maddr;
    logic [DW-1:0] wd;
    logic [MW-1:0] mwdata, mrdata;
    assign wr_ready = init_done;
    assign rd_ready = init_done;
    always_comb begin
        wd = state == INIT ? '0 : wdata;
        we = state == INIT ? cnt < LAST : wr_valid && wr_ready;
        maddr = state == INIT ? cnt[ADDR_W-1:0] : waddr;
`ifdef VPE_BIAS_BANK_PARITY_EN
        par = '0;
        err = '0;
        for (int k = 0; k < LANES; k++) begin
            par[k] = ^wd[k*DATA_W +: DATA_W];
            err[k] = ^{mrdata[DW+k], mrdata[k*DATA_W +: DATA_W]};
        end
        mwdata = {par, wd};
`else
        mwdata = wd;
`endif
    end
    vpe_bias_mem #(.W(MW), .DEPTH(DEPTH)) u_mem (
        .clk(clk), .we(we), .waddr(maddr), .wdata(mwdata), .raddr(raddr), .rdata(mrdata)
    );
    // cnt runs one past DEPTH-1 so READY is entered the cycle after the last clear write
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt <= '0;
            init_done <= 1'b0;
            rd_pend <= 1'b0;
            o_data_valid <= 1'b0;
            o_data <= '0;
`ifdef VPE_BIAS_BANK_PARITY_EN
            o_parity_err <= '0;
`endif
        end else begin
            rd_pend <= rd_valid && rd_ready;
            o_data_valid <= rd_pend;
            if (rd_pend) o_data <= mrdata[DW-1:0];
`ifdef VPE_BIAS_BANK_PARITY_EN
            o_parity_err <= rd_pend ? err : '0;
`endif
            if (state == INIT) begin
                if (cnt == LAST) begin
                    state <= READY;
                    init_done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vpe_bias_bank.sv
// tb_vpe_bias_bank: scoreboard bench for vpe_bias_bank (parity checks when VPE_BIAS_BANK_PARITY_EN is defined).
module tb_vpe_bias_bank;
    logic clk = 0, rst = 1;
    logic wr_valid = 0, rd_valid = 0;
    logic [7:0] waddr = 0, raddr = 0;
    logic [63:0] wdata = 0;
    logic wr_ready, rd_ready, o_data_valid, init_done;
    logic [63:0] o_data;
`ifdef VPE_BIAS_BANK_PARITY_EN
    logic [3:0] o_parity_err;
`endif
    typedef struct {logic [63:0] d; int c; logic [3:0] p;} exp_t;
    exp_t sb[$];
    exp_t e;
    logic [63:0] model [256];
    logic [63:0] last = 0;
    logic [3:0] next_p = 0;
    int cyc = 0, checks = 0, errors = 0, n;

    vpe_bias_bank u_dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .waddr(waddr), .wdata(wdata), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .raddr(raddr), .rd_ready(rd_ready), .o_data(o_data),
        .o_data_valid(o_data_valid), .init_done(init_done)
`ifdef VPE_BIAS_BANK_PARITY_EN
        ,.o_parity_err(o_parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic wv, input int wa, input logic [63:0] wd, input logic rv, input int ra);
        @(negedge clk);
        wr_valid = wv; waddr = 8'(wa); wdata = wd;
        rd_valid = rv; raddr = 8'(ra);
        if (rv) sb.push_back('{(wv && wa == ra) ? wd : model[ra], cyc, next_p});
        if (wv) model[wa] = wd;
    endtask

    task automatic idle(input int k);
        repeat (k) step(0, 0, 0, 0, 0);
    endtask

    task automatic wait_init;
        n = 0;
        while (!init_done && n < 400) begin
            @(posedge clk); #1; n++;
            if (n == 100) begin wr_valid = 0; rd_valid = 0; end
        end
        check("init_latency", 64'(n), 64'd257);
        check("wr_ready", {63'd0, wr_ready}, 64'd1);
        check("rd_ready", {63'd0, rd_ready}, 64'd1);
        foreach (model[i]) model[i] = '0;
    endtask

    always @(posedge clk) begin
        #1; cyc++;
        if (o_data_valid) begin
            if (sb.size() == 0) check("spurious_valid", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                check("data", o_data, e.d);
                check("latency", 64'(cyc - e.c), 64'd2);
                last = e.d;
`ifdef VPE_BIAS_BANK_PARITY_EN
                check("parity_err", {60'd0, o_parity_err}, {60'd0, e.p});
`endif
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_data", o_data, 64'd0);
        check("rst_valid", {63'd0, o_data_valid}, 64'd0);
        check("rst_init_done", {63'd0, init_done}, 64'd0);
        check("rst_ready", {62'd0, wr_ready, rd_ready}, 64'd0);
        rst = 0;
        // requests during INIT must be ignored: no output, no stored write
        wr_valid = 1; waddr = 20; wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        rd_valid = 1; raddr = 20;
        wait_init;
        step(0, 0, 0, 1, 5);
        step(1, 10, 64'h0004_0003_0002_0001, 0, 0);
        step(0, 0, 0, 1, 10);
        for (int i = 0; i < 8; i++) step(1, i, 64'h1111_0000_0000_0000 * (i + 1) + 64'(i), 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, i);
        step(1, 3, 64'hFFFF_0000_FFFF_0000, 1, 3);
        step(0, 0, 0, 1, 20);
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), {$urandom, $urandom},
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        idle(5);
        check("hold", o_data, last);
        check("drain", 64'(sb.size()), 64'd0);
`ifdef VPE_BIAS_BANK_PARITY_EN
        step(1, 7, 64'h1234_5678_9ABC_DEF0, 0, 0);
        idle(2);
        u_dut.u_mem.mem[7][32] = ~u_dut.u_mem.mem[7][32];
        model[7][32] = ~model[7][32];
        next_p = 4'b0100;
        step(0, 0, 0, 1, 7);
        next_p = 0;
        idle(4);
`endif
        // reset one cycle after a read is accepted: the read must vanish
        @(negedge clk); rd_valid = 1; raddr = 10;
        @(negedge clk); rd_valid = 0; rst = 1;
        @(posedge clk); #1;
        check("mid_rst_init_done", {63'd0, init_done}, 64'd0);
        check("mid_rst_valid", {63'd0, o_data_valid}, 64'd0);
        check("mid_rst_o_data", o_data, 64'd0);
        @(negedge clk); rst = 0;
        wait_init;
        step(0, 0, 0, 1, 10);
        idle(4);
        check("final_drain", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
